// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg
// Shared definitions for control_sequencer: FSM state encoding, pc_sel
// encodings, instruction-class enumeration, opcode match constants,
// branch condition codes and the instruction classifier.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'b00,
    PC_PLUS4 = 2'b01,
    PC_JUMP  = 2'b10,
    PC_IN    = 2'b11   // reserved, never driven
  } pc_sel_e;

  typedef enum logic [3:0] {
    CL_B, CL_BCOND, CL_CBZ, CL_CBNZ, CL_LDUR, CL_STUR,
    CL_DPREG, CL_DPIMM, CL_ILLEGAL
  } iclass_e;

  // Opcode match constants
  localparam logic [5:0]  OP_B      = 6'b000101;      // ir[31:26]
  localparam logic [7:0]  OP_BCOND  = 8'b01010100;    // ir[31:24]
  localparam logic [7:0]  OP_CBZ    = 8'b10110100;    // ir[31:24]
  localparam logic [7:0]  OP_CBNZ   = 8'b10110101;    // ir[31:24]
  localparam logic [10:0] OP_LDUR   = 11'b11111000010; // ir[31:21]
  localparam logic [10:0] OP_STUR   = 11'b11111000000; // ir[31:21]
  localparam logic [3:0]  OP_DPREG  = 4'b0101;        // ir[28:25]
  localparam logic [2:0]  OP_DPIMM  = 3'b100;         // ir[28:26]

  // Branch condition codes (ir[3:0] of B.cond)
  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_HS = 4'd2;
  localparam logic [3:0] CC_LO = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;  // behaves as AL

  // Priority-ordered instruction classification.
  function automatic iclass_e classify(input logic [31:0] ir);
    iclass_e c;
    if (ir[31:26] == OP_B)          c = CL_B;
    else if (ir[31:24] == OP_BCOND) c = CL_BCOND;
    else if (ir[31:24] == OP_CBZ)   c = CL_CBZ;
    else if (ir[31:24] == OP_CBNZ)  c = CL_CBNZ;
    else if (ir[31:21] == OP_LDUR)  c = CL_LDUR;
    else if (ir[31:21] == OP_STUR)  c = CL_STUR;
    else if (ir[28:25] == OP_DPREG) c = CL_DPREG;
    else if (ir[28:26] == OP_DPIMM) c = CL_DPIMM;
    else                            c = CL_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
// Memory/instruction handshake between the sequencer and the memory side.
//   ir        : instruction word from memory (memory -> sequencer)
//   mem_ready : memory completes the current request (memory -> sequencer)
//   mem_req   : memory request strobe (sequencer -> memory)
//   mem_we    : memory write strobe (sequencer -> memory)
//   ir_load   : sequencer captures ir this cycle (sequencer -> memory)
// master = sequencer side, slave = memory side.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        ir_load;

  modport master (
    input  ir, mem_ready,
    output mem_req, mem_we, ir_load
  );

  modport slave (
    output ir, mem_ready,
    input  mem_req, mem_we, ir_load
  );
endinterface

// File: rtl/control_sequencer_cond_eval.sv
// cond_eval
// Evaluates a B.cond condition code against the {V,C,N,Z} flags.
//   cond   [3:0] in  : condition code; 1110 and 1111 are both "always"
//   status [3:0] in  : flags {V,C,N,Z}
//   take         out : branch condition is true
module cond_eval
  import ctrl_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       take
);

  logic flag_v, flag_c, flag_n, flag_z;
  assign {flag_v, flag_c, flag_n, flag_z} = status;

  always_comb begin
    take = 1'b1;
    case (cond)
      CC_EQ:   take = flag_z;
      CC_NE:   take = !flag_z;
      CC_HS:   take = flag_c;
      CC_LO:   take = !flag_c;
      CC_MI:   take = flag_n;
      CC_PL:   take = !flag_n;
      CC_VS:   take = flag_v;
      CC_VC:   take = !flag_v;
      CC_HI:   take = flag_c && !flag_z;
      CC_LS:   take = !(flag_c && !flag_z);
      CC_GE:   take = (flag_n == flag_v);
      CC_LT:   take = (flag_n != flag_v);
      CC_GT:   take = !flag_z && (flag_n == flag_v);
      CC_LE:   take = !(!flag_z && (flag_n == flag_v));
      default: take = 1'b1;  // CC_AL and CC_NV
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
// Multi-cycle instruction control FSM: FETCH -> DECODE -> EXEC -> (MEM) ->
// (WB) -> FETCH, with a sticky FAULT state for illegal instructions and
// memory wait timeouts.
// Parameters:
//   PC_W     : width of the constant/offset output k
//   WAIT_MAX : mem_ready-low cycles tolerated in FETCH or MEM before FAULT
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   bus (master)   : ir, mem_ready in; mem_req, mem_we, ir_load out
//   status [3:0]   : flags {V,C,N,Z}, used by B.cond in EXEC
//   zero_in        : CBZ/CBNZ operand-is-zero flag
//   pc_sel [1:0]   : 00 HOLD, 01 PLUS4, 10 JUMP
//   reg_we         : register-file write strobe
//   k [PC_W-1:0]   : constant/offset decoded from the registered IR
//   state [2:0]    : current FSM state
//   fault          : sticky fault flag
//   retired [31:0] : retired-instruction count
// Configuration macro: CTRL_RETIRE_CNT_EN enables the retired counter;
// without it retired is tied to zero.
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int PC_W     = 64,
  parameter int WAIT_MAX = 15
) (
  input  logic                clock,
  input  logic                reset,
  control_sequencer_if.master bus,
  input  logic [3:0]          status,
  input  logic                zero_in,
  output logic [1:0]          pc_sel,
  output logic                reg_we,
  output logic [PC_W-1:0]     k,
  output logic [2:0]          state,
  output logic                fault,
  output logic [31:0]         retired
);

  localparam int WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d, wait_inc;
  logic [31:0]       ir_q;
  iclass_e           iclass;
  logic              cond_take;

  pc_sel_e           pc_sel_c;
  logic              mem_req_c, mem_we_c, ir_load_c, reg_we_c;

  assign iclass   = classify(ir_q);
  assign wait_inc = wait_q + 1'b1;

  cond_eval u_cond_eval (
    .cond   (ir_q[3:0]),
    .status (status),
    .take   (cond_take)
  );

  // k follows the registered IR, so it is valid from DECODE until the
  // next ir_load replaces ir_q; after reset ir_q=0 decodes as illegal -> 0.
  always_comb begin
    k = '0;
    case (iclass)
      CL_B:                     k = {{(PC_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
      CL_BCOND, CL_CBZ, CL_CBNZ: k = {{(PC_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};
      CL_LDUR, CL_STUR:         k = {{(PC_W-9){ir_q[20]}}, ir_q[20:12]};
      CL_DPIMM:                 k = {{(PC_W-12){1'b0}}, ir_q[21:10]};
      default:                  k = '0;
    endcase
  end

  // Next-state and strobe logic
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;       // any cycle outside a wait clears the run count
    pc_sel_c  = PC_HOLD;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    ir_load_c = 1'b0;
    reg_we_c  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_load_c = 1'b1;
          state_d   = ST_DECODE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_LIM) state_d = ST_FAULT;
        end
      end

      ST_DECODE: state_d = ST_EXEC;

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (iclass)
          CL_B:              pc_sel_c = PC_JUMP;
          CL_BCOND:          pc_sel_c = cond_take ? PC_JUMP : PC_PLUS4;
          CL_CBZ:            pc_sel_c = zero_in ? PC_JUMP : PC_PLUS4;
          CL_CBNZ:           pc_sel_c = zero_in ? PC_PLUS4 : PC_JUMP;
          CL_LDUR, CL_STUR:  state_d  = ST_MEM;
          CL_DPREG, CL_DPIMM: state_d = ST_WB;
          default:           state_d  = ST_FAULT;
        endcase
      end

      ST_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (iclass == CL_STUR);
        if (bus.mem_ready) begin
          if (iclass == CL_STUR) begin
            pc_sel_c = PC_PLUS4;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_WB;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_LIM) state_d = ST_FAULT;
        end
      end

      ST_WB: begin
        reg_we_c = 1'b1;
        pc_sel_c = PC_PLUS4;
        state_d  = ST_FETCH;
      end

      ST_FAULT: state_d = ST_FAULT;

      default: state_d = ST_FAULT;  // unused encodings
    endcase
  end

  // State, wait counter and instruction register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (ir_load_c) ir_q <= bus.ir;
    end
  end

  // Strobes are held quiet during a reset cycle, whatever state is current.
  assign pc_sel      = reset ? PC_HOLD : pc_sel_c;
  assign bus.mem_req = reset ? 1'b0 : mem_req_c;
  assign bus.mem_we  = reset ? 1'b0 : mem_we_c;
  assign bus.ir_load = reset ? 1'b0 : ir_load_c;
  assign reg_we      = reset ? 1'b0 : reg_we_c;
  assign state       = state_q;
  assign fault       = (state_q == ST_FAULT);

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
    end else if (pc_sel != PC_HOLD) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 64, meaning the width of k.
REQ-002 SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of mem_ready-low cycles tolerated in FETCH or MEM.
REQ-003 SHALL have port clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port ir  in  32  instruction word from memory, sampled when ir_load=1.
REQ-006 SHALL have port status  in  4  flags {V,C,N,Z}.
REQ-007 SHALL have port zero_in  in  1  CBZ/CBNZ operand-is-zero flag.
REQ-008 SHALL have port mem_ready  in  1  memory completes the current request.
REQ-009 SHALL have port pc_sel  out  2  PC control: 00 HOLD, 01 PLUS4, 10 JUMP, 11 IN (IN is reserved and never driven).
REQ-010 SHALL have port ir_load  out  1  capture ir this cycle.
REQ-011 SHALL have ports mem_req, mem_we and reg_we  out  1  each; memory request, memory write and register-file write strobes.
REQ-012 SHALL have port k  out  PC_W  constant/offset.
REQ-013 SHALL have port state  out  3  current state.
REQ-014 SHALL have port fault  out  1  sticky fault flag.
REQ-015 SHALL have port retired  out  32  retired-instruction count.

Function
REQ-016 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
REQ-017 SHALL, in FETCH, assert mem_req; when mem_ready=1, assert ir_load combinationally, register ir and go to DECODE; otherwise stay in FETCH.
REQ-018 SHALL, in DECODE, classify the registered IR in this priority order:
- B: [31:26]=000101
- B.cond: [31:24]=01010100
- CBZ: [31:24]=10110100
- CBNZ: [31:24]=10110101
- LDUR: [31:21]=11111000010
- STUR: [31:21]=11111000000
- DP-reg: [28:24]=0101x
- DP-imm: [28:26]=100
- anything else: illegal.
REQ-019 SHALL always go from DECODE to EXEC.
REQ-020 SHALL drive k from DECODE until the next ir_load as follows:
- B: sext(imm26)<<2.
- B.cond, CBZ, CBNZ: sext(imm19)<<2.
- LDUR, STUR: sext(imm9).
- DP-imm: zext(imm12).
- DP-reg: zero.
REQ-021 SHALL, in EXEC, handle each class as follows, then return to FETCH unless stated:
- B: pc_sel=JUMP.
- B.cond: pc_sel=JUMP if the condition is true, else PLUS4.
- CBZ: pc_sel=JUMP if zero_in=1, else PLUS4; CBNZ is the inverse.
- LDUR, STUR: go to MEM.
- DP: go to WB.
- Illegal: go to FAULT.
REQ-022 SHALL evaluate B.cond conditions EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL from ir[3:0] and the status value sampled in EXEC; ir[3:0]=1111 SHALL be treated as AL.
REQ-023 SHALL, in MEM, assert mem_req (and mem_we for STUR) until mem_ready=1; then LDUR goes to WB, and STUR drives pc_sel=PLUS4 and goes to FETCH.
REQ-024 SHALL, in WB, assert reg_we and drive pc_sel=PLUS4 for exactly one cycle, then go to FETCH.
REQ-025 SHALL drive pc_sel=HOLD and deassert strobes in every cycle not listed above.
REQ-026 SHALL count consecutive mem_ready-low cycles in FETCH or MEM, clear the count on entering either state, and go to FAULT when the count reaches WAIT_MAX.
REQ-027 SHALL keep FAULT sticky until reset, with fault=1, all strobes 0 and pc_sel=HOLD.
REQ-028 SHALL give DP latency of 4 cycles and LDUR latency of 5 cycles with zero-wait memory.

Reset
REQ-029 SHALL, when reset=1 at a clock edge in any state (including mid-MEM), enter FETCH with state=0, k=0, fault=0, retired=0, the wait counter at 0, and the registered IR at 0.

Configuration
REQ-030 SHALL, with CTRL_RETIRE_CNT_EN defined, increment retired (wrapping modulo 2^32) in every cycle where pc_sel is not HOLD.
REQ-031 SHALL, without CTRL_RETIRE_CNT_EN, tie retired to 0 and infer no counter logic.

Structure
REQ-032 SHALL place the state encoding, pc_sel encodings, opcode match constants and condition codes in shared package ctrl_seq_pkg.
REQ-033 SHALL implement condition evaluation in sub-module cond_eval (inputs cond[3:0] and status[3:0], output take).

Verification
REQ-034 SHALL check: reset, then ir=0xAA0003E3 (ORR) with mem_ready=1 -> state sequence 0,1,2,4,0; reg_we high only in WB; retired=1 (with CTRL_RETIRE_CNT_EN).
REQ-035 SHALL check: ir=0x54000040 (B.EQ, imm19=2) with Z=1 -> pc_sel=10 and k=8 in EXEC; with Z=0 -> pc_sel=01.
REQ-036 SHALL check: ir=0x17FFFFFF (B, imm26 all ones) -> k=0xFFFF_FFFF_FFFF_FFFC and pc_sel=10 in EXEC.
REQ-037 SHALL check: LDUR with mem_ready low for 3 cycles in MEM and WAIT_MAX=15 -> MEM held 3 cycles, then WB; the same stimulus with WAIT_MAX=2 -> FAULT, fault=1 held until reset.
REQ-038 SHALL check: reset pulsed while in MEM -> next state=0, mem_req=0, retired=0, fault=0.
REQ-039 SHALL check: ir=0x00000000 -> FAULT after EXEC with pc_sel held at 00.
